// File: rtl/pulse_train_generator.sv
// Pulse train generator: emits num_pulses high pulses of high_len cycles
// separated by low_len low cycles, then a one-cycle done strobe.
//
// Ports:
//   clk        : clock, all state changes on its rising edge
//   rst        : asynchronous active-high reset
//   start      : begin a train (accepted only in IDLE)
//   abort      : cancel a running train (HIGH/LOW only), no done strobe
//   num_pulses : number of pulses (0 gives a bare done strobe)
//   high_len   : high cycles per pulse (0 treated as 1)
//   low_len    : low cycles between pulses (0 treated as 1)
//   out        : registered pulse train
//   busy       : registered, train in progress
//   done       : registered one-cycle completion strobe
module pulse_train_generator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  output logic             out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_left;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_m1;
  logic [CNT_W-1:0] r_low_m1;
  logic             r_out;
  logic             r_busy;
  logic             r_done;

  // Phase lengths are kept as "length minus one" so the phase counter
  // counts down to zero; a length of 0 collapses to 1 here, and a full
  // 2^CNT_W-1 length still fits without wrapping.
  logic [CNT_W-1:0] w_high_m1;
  logic [CNT_W-1:0] w_low_m1;

  assign w_high_m1 = (high_len == '0) ? '0 : high_len - 1'b1;
  assign w_low_m1  = (low_len == '0) ? '0 : low_len - 1'b1;

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

  // r_left holds the pulses still owed, counting the one in progress,
  // so r_left==1 at the end of HIGH marks the last pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_left    <= '0;
      r_cnt     <= '0;
      r_high_m1 <= '0;
      r_low_m1  <= '0;
      r_out     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_high_m1 <= w_high_m1;
            r_low_m1  <= w_low_m1;
            r_left    <= num_pulses;
            r_cnt     <= w_high_m1;
            if (num_pulses == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_HIGH;
              r_out   <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_left == 1) begin
            r_state <= S_DONE;
            r_left  <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_LOW;
            r_left  <= r_left - 1'b1;
            r_cnt   <= r_low_m1;
            r_out   <= 1'b0;
          end
        end
        S_LOW: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= S_HIGH;
            r_cnt   <= r_high_m1;
            r_out   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Testbench for pulse_train_generator: queue-based reference model
// plus directed literal sequences and randomized traffic.
module tb_pulse_train_generator;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] num;
  logic [7:0] hi;
  logic [7:0] lo;
  logic       out;
  logic       busy;
  logic       done;

  int n_chk;
  int n_err;

  // {out, busy, done} for the current cycle and the cycles to come
  logic [2:0] cur;
  logic [2:0] q[$];

  pulse_train_generator #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .num_pulses (num),
    .high_len   (hi),
    .low_len    (lo),
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Whole train laid out in advance from the rules.
  task automatic build(input int n, input int h, input int l);
    int hh;
    int ll;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    for (int p = 0; p < n; p++) begin
      repeat (hh) q.push_back(3'b110);
      if (p < n - 1) repeat (ll) q.push_back(3'b010);
    end
    q.push_back(3'b001);
  endtask

  task automatic model_step();
    if (rst) begin
      q.delete();
      cur = 3'b000;
    end else if (abort && cur[1]) begin
      q.delete();
      cur = 3'b000;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (start && !cur[0]) begin
      build(int'(num), int'(hi), int'(lo));
      cur = q.pop_front();
    end else begin
      cur = 3'b000;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cycle", {29'd0, out, busy, done}, {29'd0, cur});
  endtask

  task automatic run(input int n, input int h, input int l,
                     input int len, input bit disturb,
                     output logic [31:0] ov, output logic [31:0] bv,
                     output logic [31:0] dv);
    ov = '0;
    bv = '0;
    dv = '0;
    num = n[7:0];
    hi = h[7:0];
    lo = l[7:0];
    start = 1'b1;
    for (int k = 1; k <= len; k++) begin
      tick();
      start = 1'b0;
      if (disturb && k == 3) begin
        start = 1'b1;
        num = 8'($urandom);
        hi = 8'($urandom);
        lo = 8'($urandom);
      end
      if (k < 32) begin
        ov[k] = out;
        bv[k] = busy;
        dv[k] = done;
      end
    end
    start = 1'b0;
  endtask

  logic [31:0] ov;
  logic [31:0] bv;
  logic [31:0] dv;
  logic [31:0] acc;

  initial begin
    n_chk = 0;
    n_err = 0;
    cur = 3'b000;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    num = '0;
    hi = '0;
    lo = '0;
    #12;
    chk("reset_state", {29'd0, out, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single pulse
    run(1, 1, 5, 4, 1'b0, ov, bv, dv);
    chk("single_out", ov, 32'h2);
    chk("single_busy", bv, 32'h2);
    chk("single_done", dv, 32'h4);

    // three pulse train
    run(3, 2, 1, 11, 1'b0, ov, bv, dv);
    chk("train_out", ov, 32'h1B6);
    chk("train_busy", bv, 32'h1FE);
    chk("train_done", dv, 32'h200);

    // zero lengths
    run(2, 0, 0, 6, 1'b0, ov, bv, dv);
    chk("zlen_out", ov, 32'hA);
    chk("zlen_done", dv, 32'h10);

    // zero count
    run(0, 3, 3, 3, 1'b0, ov, bv, dv);
    chk("zcnt_out", ov, 32'h0);
    chk("zcnt_busy", bv, 32'h0);
    chk("zcnt_done", dv, 32'h2);

    // ignored start and changed config mid-train
    run(2, 3, 2, 12, 1'b1, ov, bv, dv);
    chk("latch_out", ov, 32'h1CE);
    chk("latch_done", dv, 32'h200);
    chk("latch_ndone", 32'($countones(dv)), 32'd1);

    // abort during LOW of a 4-pulse train
    num = 8'd4;
    hi = 8'd2;
    lo = 8'd3;
    start = 1'b1;
    acc = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      start = 1'b0;
      acc[k] = done;
    end
    chk("abort_in_low", {31'd0, busy & ~out}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    acc[5] = done;
    chk("abort_outs", {29'd0, out, busy, done}, 32'd0);
    tick();
    acc[6] = done;
    chk("abort_nodone", acc, 32'd0);
    run(4, 2, 3, 20, 1'b0, ov, bv, dv);
    chk("restart_out", ov, 32'h318C6);
    chk("restart_done", dv, 32'h40000);

    // asynchronous reset during HIGH
    num = 8'd3;
    hi = 8'd4;
    lo = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_high", {31'd0, out}, 32'd1);
    @(posedge clk);
    model_step();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_immediate", {29'd0, out, busy, done}, 32'd0);
    q.delete();
    cur = 3'b000;
    @(negedge clk);
    tick();
    rst = 1'b0;
    acc = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      acc[k] = done;
    end
    chk("rst_nodone", acc, 32'd0);
    run(2, 1, 1, 6, 1'b0, ov, bv, dv);
    chk("post_rst_out", ov, 32'hA);
    chk("post_rst_done", dv, 32'h10);

    // full-scale fields
    run(2, 255, 255, 770, 1'b0, ov, bv, dv);
    run(255, 1, 1, 512, 1'b0, ov, bv, dv);
    chk("max_num_done", {31'd0, done}, 32'd0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        num = 8'($urandom_range(0, 4));
        hi = 8'($urandom_range(0, 4));
        lo = 8'($urandom_range(0, 4));
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (60) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

Interface
REQ-001 SHALL have parameter CNT_W, default 8, the width of every count and length field.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a pulse train.
REQ-005 SHALL have port abort  input  1  synchronous cancel of a running train.
REQ-006 SHALL have port num_pulses  input  CNT_W  number of pulses to emit.
REQ-007 SHALL have port high_len  input  CNT_W  cycles each pulse stays high.
REQ-008 SHALL have port low_len  input  CNT_W  low cycles between consecutive pulses.
REQ-009 SHALL have port out  output  1  generated pulse train, registered.
REQ-010 SHALL have port busy  output  1  train in progress, registered.
REQ-011 SHALL have port done  output  1  one-cycle completion strobe, registered.

Function
REQ-012 SHALL implement states IDLE, HIGH, LOW and DONE.
REQ-013 SHALL, in IDLE with start=1, latch num_pulses, high_len and low_len.
- Later changes to these inputs SHALL NOT affect the running train.
REQ-014 SHALL treat a latched high_len of 0 as 1 and a latched low_len of 0 as 1, so pulses never merge.
REQ-015 SHALL, on start in IDLE with num_pulses>0, enter HIGH.
- out=1 and busy=1 from the next cycle.
REQ-016 SHALL hold HIGH for exactly high_len cycles, then take one of two paths:
- more pulses remain: enter LOW (out=0, busy=1) for exactly low_len cycles, then return to HIGH;
- last pulse: enter DONE.
REQ-017 SHALL, in DONE, drive done=1, out=0 and busy=0 for exactly one cycle, then enter IDLE.
- No trailing low gap follows the last pulse.
REQ-018 SHALL, on start in IDLE with num_pulses=0, enter DONE directly.
- done=1 in the next cycle; out stays 0 throughout.
REQ-019 SHALL ignore start in every state other than IDLE.
- This includes the DONE cycle; the earliest restart is start sampled in the IDLE cycle after DONE.
REQ-020 SHALL, on abort=1 in HIGH or LOW, enter IDLE in the next cycle.
- out=0, busy=0; done is NOT asserted.
REQ-021 SHALL give abort priority over the HIGH/LOW/DONE transitions in the same cycle.
- abort in IDLE or DONE has no effect.
- abort and start together in IDLE: start SHALL be accepted.
REQ-022 SHALL use internal counters of CNT_W bits with no wrap-around.
- num_pulses, high_len and low_len of 2^CNT_W-1 SHALL be honoured exactly.
REQ-023 SHALL keep out, busy and done all registered; no combinational path from any input to any output.
REQ-024 SHALL keep done mutually exclusive with busy and with out.

Reset
REQ-025 SHALL, while rst=1, force state=IDLE, out=0, busy=0, done=0 and all counters to 0, independent of clk.
REQ-026 SHALL, on rst asserted mid-train, drop out immediately with no done strobe.
- After release, the block SHALL accept a new start normally.

Verification
REQ-027 Single pulse: start with num=1, high=1, low=5.
- out = 0,1,0 (cycles 0,1,2 after start).
- done=1 at cycle 2; busy=1 only at cycle 1.
REQ-028 Train: start with num=3, high=2, low=1.
- out from cycle 1 = 1,1,0,1,1,0,1,1.
- done=1 at cycle 9; busy=1 at cycles 1-8.
REQ-029 Zero lengths and zero count:
- num=2, high=0, low=0 gives out = 1,0,1, then done;
- num=0 gives done at cycle 1 and out=0 throughout.
REQ-030 Ignored start and latched config: start pulsed, and num/high/low changed, during a num=2, high=3, low=2 train.
- Output matches an undisturbed train; exactly one done.
REQ-031 Abort in LOW of a num=4 train.
- out=0, busy=0 the next cycle; no done.
- A new start next cycle runs a full train.
REQ-032 Reset mid-train: rst asserted asynchronously, between clk edges, during HIGH.
- out, busy and done go 0 immediately; no done after release.
